gate_sweep_checker: RTL and testbench
=====================================

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning the number of cycles each input vector is held before gate outputs are sampled (legal 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: requests one full sweep.
REQ-005 SHALL have port gate_out, input, 7 bits, observed outputs of the gates under test: [0] not(in1), [1] nand, [2] nor, [3] and, [4] or, [5] xor, [6] xnor.
REQ-006 SHALL have ports in1 and in2, output, 1 bit each: stimulus driven to every gate under test.
REQ-007 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-008 SHALL have port done, output, 1 bit: high from sweep completion until the next accepted start or rst.
REQ-009 SHALL have port pass, output, 1 bit: equals 1 exactly when done=1 and fail_mask=0.
REQ-010 SHALL have port fail_mask, output, 7 bits: sticky per-gate mismatch flags, using the same bit order as gate_out.
REQ-011 SHALL have port err_count, output, 5 bits: total mismatching bit-samples in the sweep (max 28, so no saturation is needed).

Function
REQ-012 SHALL implement the states IDLE, SETTLE and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start while busy SHALL be ignored.
REQ-014 On the edge where start is accepted (call it edge T0), the block SHALL clear fail_mask, err_count, done and pass, drive {in1,in2}=2'b00, set busy=1 and enter SETTLE.
REQ-015 Vector k (k=0..3, {in1,in2}=k) SHALL be driven from edge T0+k*SETTLE_CYCLES.
REQ-016 Each vector SHALL be sampled at edge T0+(k+1)*SETTLE_CYCLES, and that same edge SHALL drive vector k+1.
REQ-017 The expected value per gate SHALL be the ideal Boolean function of the current in1/in2; the not gate uses in1 only.
REQ-018 The mismatch bit for gate i SHALL be set when gate_out[i] is not identical to expected[i]; X or Z SHALL count as a mismatch (case-equality compare).
REQ-019 At each sample, fail_mask SHALL be ORed with the mismatch vector and err_count SHALL increase by its population count (0..7).
REQ-020 At the edge sampling vector 3 (T0+4*SETTLE_CYCLES), the block SHALL set busy=0, set done=1, enter DONE, and return {in1,in2} to 2'b00.
REQ-021 pass SHALL be combinational from done and fail_mask, valid only while done=1.
REQ-022 start together with rst in the same cycle: rst SHALL win.

Reset
REQ-023 When rst=1 at a clock edge, the block SHALL enter IDLE and set in1=0, in2=0, busy=0, done=0, pass=0, fail_mask=0 and err_count=0, regardless of state, including mid-sweep.
REQ-024 After reset, the block SHALL require a fresh start; a sweep interrupted by rst SHALL NOT resume.

Structure
REQ-025 Package gate_check_pkg SHALL hold the state enum, NUM_GATES=7, the gate index constants (GATE_NOT..GATE_XNOR) and the expected-vector function.
REQ-026 Sub-module gate_expect SHALL compute the 7-bit expected vector from in1/in2 combinationally; the settle counter and vector counter stay in gate_sweep_checker.

Verification
REQ-027 Ideal gates, SETTLE_CYCLES=2, start at edge 0 -> vectors change at edges 0/2/4/6, done=1 at edge 8, pass=1, fail_mask=7'h00, err_count=0.
REQ-028 gate_out[5] tied 0, otherwise ideal -> fail_mask=7'b0100000, err_count=2, pass=0.
REQ-029 gate_out all Z -> fail_mask=7'h7F, err_count=28, pass=0.
REQ-030 Second start pulsed at edge 3 -> ignored, done still at edge 8; start in DONE -> outputs cleared and a full new sweep runs.
REQ-031 rst at edge 5 mid-sweep -> next cycle IDLE and all outputs 0; a later start gives a complete, correct sweep.
REQ-032 SETTLE_CYCLES=1, ideal gates -> done=1 at edge 4, pass=1.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate sweep checker: FSM states, gate
// bit positions and the ideal truth-table function.
package gate_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int NUM_GATES = 7;

  localparam int GATE_NOT  = 0;
  localparam int GATE_NAND = 1;
  localparam int GATE_NOR  = 2;
  localparam int GATE_AND  = 3;
  localparam int GATE_OR   = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  function automatic logic [NUM_GATES-1:0] expected_vec(input logic a, input logic b);
    logic [NUM_GATES-1:0] v;
    v            = '0;
    v[GATE_NOT]  = ~a;
    v[GATE_NAND] = ~(a & b);
    v[GATE_NOR]  = ~(a | b);
    v[GATE_AND]  = a & b;
    v[GATE_OR]   = a | b;
    v[GATE_XOR]  = a ^ b;
    v[GATE_XNOR] = ~(a ^ b);
    return v;
  endfunction

endpackage

// File: rtl/gate_expect.sv
// Combinational reference: ideal output of every gate under test for the
// stimulus currently being driven.
module gate_expect
  import gate_check_pkg::*;
(
  input  logic                 in1,
  input  logic                 in2,
  output logic [NUM_GATES-1:0] expected
);

  assign expected = expected_vec(in1, in2);

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives all four {in1,in2} vectors to a bank of gates, holds each for
// SETTLE_CYCLES, and accumulates per-gate mismatch flags and an error count.
module gate_sweep_checker
  import gate_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_GATES-1:0] gate_out,
  output logic                 in1,
  output logic                 in2,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] fail_mask,
  output logic [4:0]           err_count
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t               r_state;
  logic [3:0]           r_settle_cnt;
  logic                 r_in1;
  logic                 r_in2;
  logic                 r_busy;
  logic                 r_done;
  logic [NUM_GATES-1:0] r_fail_mask;
  logic [4:0]           r_err_count;

  logic [NUM_GATES-1:0] w_expected;
  logic [NUM_GATES-1:0] w_mismatch;

  // Case inequality so that X/Z on an observed gate output counts as a miss.
  function automatic logic [NUM_GATES-1:0] mismatch_vec(
    input logic [NUM_GATES-1:0] obs,
    input logic [NUM_GATES-1:0] exp
  );
    logic [NUM_GATES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      m[i] = (obs[i] !== exp[i]);
    end
    return m;
  endfunction

  function automatic logic [4:0] popcount(input logic [NUM_GATES-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  gate_expect u_expect (
    .in1      (r_in1),
    .in2      (r_in2),
    .expected (w_expected)
  );

  assign w_mismatch = mismatch_vec(gate_out, w_expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_in1        <= 1'b0;
      r_in2        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail_mask  <= '0;
      r_err_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
            r_in1        <= 1'b0;
            r_in2        <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_fail_mask  <= '0;
            r_err_count  <= '0;
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            r_settle_cnt <= '0;
            r_fail_mask  <= r_fail_mask | w_mismatch;
            r_err_count  <= r_err_count + popcount(w_mismatch);
            // The stimulus itself is the vector index; 2'b11 is the last one.
            if ({r_in1, r_in2} == 2'b11) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_in1   <= 1'b0;
              r_in2   <= 1'b0;
            end else begin
              {r_in1, r_in2} <= {r_in1, r_in2} + 2'd1;
            end
          end else begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in1       = r_in1;
  assign in2       = r_in2;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fail_mask = r_fail_mask;
  assign err_count = r_err_count;
  assign pass      = r_done && (r_fail_mask == '0);

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two instances (SETTLE_CYCLES=2 and 1) fed by a
// configurable gate model, table vectors, hand sequences and random faults.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, sel;
  int   mode;
  logic [6:0] rmask [4];

  logic       a_start, a_in1, a_in2, a_busy, a_done, a_pass;
  logic [6:0] a_go, a_fm;
  logic [4:0] a_ec;
  logic       b_start, b_in1, b_in2, b_busy, b_done, b_pass;
  logic [6:0] b_go, b_fm;
  logic [4:0] b_ec;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int         mode;
    logic [6:0] fm;
    logic [4:0] ec;
    logic       ps;
    int         s;
    int         extra_at;
  } vec_t;
  vec_t tbl [7];

  gate_sweep_checker #(.SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .gate_out(a_go),
    .in1(a_in1), .in2(a_in2), .busy(a_busy), .done(a_done), .pass(a_pass),
    .fail_mask(a_fm), .err_count(a_ec)
  );

  gate_sweep_checker #(.SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .gate_out(b_go),
    .in1(b_in1), .in2(b_in2), .busy(b_busy), .done(b_done), .pass(b_pass),
    .fail_mask(b_fm), .err_count(b_ec)
  );

  assign a_start = start & ~sel;
  assign b_start = start & sel;

  function automatic logic [6:0] ideal(input logic a, input logic b);
    return {~(a ^ b), a ^ b, a | b, a & b, ~(a | b), ~(a & b), ~a};
  endfunction

  // Behaviour of the gate bank in each fault mode.
  function automatic logic [6:0] drive(input int m, input logic a, input logic b,
                                       input logic [6:0] rm);
    case (m)
      0:       return ideal(a, b);
      1:       return ideal(a, b) & ~7'b0100000;
      2:       return 7'bzzzzzzz;
      3:       return ideal(a, b) | 7'b0000001;
      4:       return 7'b0000000;
      5:       return ~ideal(a, b);
      default: return ideal(a, b) ^ rm;
    endcase
  endfunction

  always_comb a_go = drive(mode, a_in1, a_in2, rmask[{a_in1, a_in2}]);
  always_comb b_go = drive(mode, b_in1, b_in2, rmask[{b_in1, b_in2}]);

  logic [1:0] o_in;
  logic       o_busy, o_done, o_pass;
  logic [6:0] o_fm;
  logic [4:0] o_ec;
  assign o_in   = sel ? {b_in1, b_in2} : {a_in1, a_in2};
  assign o_busy = sel ? b_busy : a_busy;
  assign o_done = sel ? b_done : a_done;
  assign o_pass = sel ? b_pass : a_pass;
  assign o_fm   = sel ? b_fm : a_fm;
  assign o_ec   = sel ? b_ec : a_ec;

  // Reference: walk the four vectors and tally every differing gate bit.
  task automatic model(input int m, output logic [6:0] fm, output logic [4:0] ec);
    logic [6:0] g, e;
    fm = '0;
    ec = '0;
    for (int v = 0; v < 4; v++) begin
      e = ideal(v[1], v[0]);
      g = drive(m, v[1], v[0], rmask[v]);
      for (int i = 0; i < 7; i++) begin
        if (g[i] !== e[i]) begin
          fm[i] = 1'b1;
          ec    = ec + 5'd1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " in"}, 32'(o_in), 0);
    chk({tag, " busy"}, 32'(o_busy), 0);
    chk({tag, " done"}, 32'(o_done), 0);
    chk({tag, " pass"}, 32'(o_pass), 0);
    chk({tag, " fail_mask"}, 32'(o_fm), 0);
    chk({tag, " err_count"}, 32'(o_ec), 0);
  endtask

  // One sweep; extra_at pulses start so it is sampled at edge T0+extra_at.
  task automatic sweep(input int s, input int extra_at, input logic [6:0] efm,
                       input logic [4:0] eec, input logic eps);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 4 * s; c++) begin
      @(negedge clk);
      start = (c + 1 == extra_at);
      if (c == 0) begin
        chk("start fail_mask cleared", 32'(o_fm), 0);
        chk("start err_count cleared", 32'(o_ec), 0);
        chk("start done cleared", 32'(o_done), 0);
        chk("start pass cleared", 32'(o_pass), 0);
      end
      chk($sformatf("vector at T0+%0d", c), 32'(o_in), 32'(c / s));
      chk($sformatf("busy at T0+%0d", c), 32'(o_busy), 1);
      chk($sformatf("done at T0+%0d", c), 32'(o_done), 0);
    end
    @(negedge clk);
    start = 1'b0;
    chk("end done", 32'(o_done), 1);
    chk("end busy", 32'(o_busy), 0);
    chk("end in", 32'(o_in), 0);
    chk("end fail_mask", 32'(o_fm), 32'(efm));
    chk("end err_count", 32'(o_ec), 32'(eec));
    chk("end pass", 32'(o_pass), 32'(eps));
  endtask

  initial begin
    logic [6:0] mfm;
    logic [4:0] mec;
    for (int v = 0; v < 4; v++) rmask[v] = '0;
    mode  = 0;
    sel   = 1'b0;
    rst   = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset a");
    sel = 1'b1;
    chk_idle("reset b");
    sel   = 1'b0;
    rst   = 1'b0;
    start = 1'b0;

    model(2, mfm, mec);
    tbl[0] = '{0, 7'h00, 5'd0, 1'b1, 2, 3};
    tbl[1] = '{1, 7'b0100000, 5'd2, 1'b0, 2, -1};
    tbl[2] = '{2, 7'h7F, mec, 1'b0, 2, -1};
    tbl[3] = '{3, 7'b0000001, 5'd2, 1'b0, 2, -1};
    tbl[4] = '{4, 7'h7F, 5'd14, 1'b0, 2, -1};
    tbl[5] = '{5, 7'h7F, 5'd28, 1'b0, 2, -1};
    tbl[6] = '{0, 7'h00, 5'd0, 1'b1, 1, -1};
    for (int t = 0; t < 7; t++) begin
      mode = tbl[t].mode;
      sel  = (tbl[t].s == 1);
      sweep(tbl[t].s, tbl[t].extra_at, tbl[t].fm, tbl[t].ec, tbl[t].ps);
    end

    // Reset at edge 5 of a failing sweep, then no resumption.
    sel  = 1'b0;
    mode = 5;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst   = (c == 4);
    end
    @(negedge clk);
    rst = 1'b0;
    chk_idle("mid-sweep reset");
    repeat (10) begin
      @(negedge clk);
      chk("no resume busy", 32'(o_busy), 0);
      chk("no resume in", 32'(o_in), 0);
    end
    mode = 1;
    sweep(2, -1, 7'b0100000, 5'd2, 1'b0);

    // Random per-vector corruption on both instances.
    mode = 6;
    for (int r = 0; r < 12; r++) begin
      int s, ex;
      sel = r[0];
      s   = sel ? 1 : 2;
      for (int v = 0; v < 4; v++)
        rmask[v] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'h00;
      ex = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4 * s - 1)) : -1;
      model(6, mfm, mec);
      sweep(s, ex, mfm, mec, (mfm == 7'h00));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
